// File: rtl/uart_tx_arb.sv
// uart_tx_arb: two-requester round-robin arbiter in front of a UART transmitter.
// A granted byte is framed as start/8 data bits LSB first/stop. The baud
// generator supplies the bit timing. Each frame is followed by GAP_CYC idle-high
// cycles before the next grant.
// Ports:
//   sclk, rst_n          clock, async active-low reset
//   a_req/a_data/a_ack   requester A (req held until ack, ack is a 1-cycle pulse)
//   b_req/b_data/b_ack   requester B
//   tx_flag              enable to the baud generator tx half (high in SEND)
//   tx_bit_flag          mid-bit strobe from the baud generator
//   tx_bit_cnt           bit index from the baud generator (0..9)
//   tx                   serial line
//   busy                 high whenever not IDLE
//   frame_done           1-cycle pulse on the stop-bit strobe
module uart_tx_arb #(
  parameter int GAP_CYC = 435
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       a_req,
  input  logic [7:0] a_data,
  output logic       a_ack,
  input  logic       b_req,
  input  logic [7:0] b_data,
  output logic       b_ack,
  output logic       tx_flag,
  input  logic       tx_bit_flag,
  input  logic [3:0] tx_bit_cnt,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [8:0] gap_cnt_q, gap_cnt_d;
  logic       last_b_q, last_b_d;   // 1: B was granted most recently
  logic       a_ack_q, a_ack_d;
  logic       b_ack_q, b_ack_d;
  logic       tx_q, tx_d;
  logic       tx_flag_q, tx_flag_d;
  logic       busy_q, busy_d;
  logic       frame_done_q, frame_done_d;
  logic       grant_a;
  logic [3:0] bit_idx;

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    gap_cnt_d    = gap_cnt_q;
    last_b_d     = last_b_q;
    tx_d         = tx_q;
    a_ack_d      = 1'b0;
    b_ack_d      = 1'b0;
    frame_done_d = 1'b0;
    // A wins unless B also asks and A was served last.
    grant_a      = a_req && (!b_req || last_b_q);
    bit_idx      = tx_bit_cnt - 4'd1;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (a_req || b_req) begin
          state_d = SEND;
          if (grant_a) begin
            data_d   = a_data;
            a_ack_d  = 1'b1;
            last_b_d = 1'b0;
          end else begin
            data_d   = b_data;
            b_ack_d  = 1'b1;
            last_b_d = 1'b1;
          end
        end
      end
      SEND: begin
        // Line only moves on a strobe. Indices above 9 are ignored.
        if (tx_bit_flag) begin
          if (tx_bit_cnt == 4'd0) begin
            tx_d = 1'b0;
          end else if (tx_bit_cnt <= 4'd8) begin
            tx_d = data_q[bit_idx[2:0]];
          end else if (tx_bit_cnt == 4'd9) begin
            tx_d         = 1'b1;
            state_d      = GAP;
            gap_cnt_d    = '0;
            frame_done_d = 1'b1;
          end
        end
      end
      GAP: begin
        tx_d = 1'b1;
        if (gap_cnt_q == 9'(GAP_CYC - 1)) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 9'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    tx_flag_d = (state_d == SEND);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      data_q       <= '0;
      gap_cnt_q    <= '0;
      last_b_q     <= 1'b1;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      tx_q         <= 1'b1;
      tx_flag_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      gap_cnt_q    <= gap_cnt_d;
      last_b_q     <= last_b_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      tx_q         <= tx_d;
      tx_flag_q    <= tx_flag_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign a_ack      = a_ack_q;
  assign b_ack      = b_ack_q;
  assign tx         = tx_q;
  assign tx_flag    = tx_flag_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter GAP_CYC, default 435, is the number of idle-high sclk cycles inserted after each frame's stop-bit strobe.
REQ-002 Port sclk  input  1  is the single clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port rst_n  input  1  is the asynchronous, active-low reset.
REQ-004 Port a_req  input  1  is requester A's byte request, held high until a_ack.
REQ-005 Port a_data  input  8  is requester A's byte, stable while a_req is high.
REQ-006 Port a_ack  output  1  is a one-cycle grant/accept pulse to A.
REQ-007 Port b_req  input  1  is requester B's byte request, held high until b_ack.
REQ-008 Port b_data  input  8  is requester B's byte, stable while b_req is high.
REQ-009 Port b_ack  output  1  is a one-cycle grant/accept pulse to B.
REQ-010 Port tx_flag  output  1  is the enable driven to the tx half of the baud generator.
REQ-011 Port tx_bit_flag  input  1  is the baud generator's mid-bit strobe.
REQ-012 Port tx_bit_cnt  input  4  is the baud generator's bit index, 0..9.
REQ-013 Port tx  output  1  is the serial UART line.
REQ-014 Port busy  output  1  is high whenever the state is not IDLE.
REQ-015 Port frame_done  output  1  is a one-cycle pulse marking the stop-bit strobe of each frame.

Function
REQ-016 The FSM SHALL have three states: IDLE, SEND and GAP.
REQ-017 In IDLE with a_req or b_req high, the block SHALL grant one requester in that cycle, latch its data into an 8-bit shift/hold register, register its ack as a one-cycle pulse, and enter SEND on the next cycle.
REQ-018 Arbitration SHALL be round-robin: when both requests are high, the requester not granted most recently wins; a lone requester always wins.
REQ-019 The last-grant register SHALL reset to B so that A wins the first contested arbitration.
REQ-020 A request withdrawn before its ack SHALL NOT be granted, and no state change SHALL occur for it.
REQ-021 tx_flag SHALL be 1 exactly while the state is SEND and 0 otherwise.
REQ-022 In SEND, on each tx_bit_flag, tx SHALL be updated according to tx_bit_cnt:
- 0: tx=0 (start bit)
- 1..8: tx=data[tx_bit_cnt-1] (LSB first)
- 9: tx=1 (stop bit)
REQ-023 In SEND, tx SHALL hold its value between strobes.
REQ-024 On tx_bit_flag with tx_bit_cnt==9, the block SHALL enter GAP, clear tx_flag on the next cycle, and pulse frame_done in that cycle.
REQ-025 tx_bit_cnt values above 9 during SEND SHALL leave tx unchanged.
REQ-026 In GAP, tx SHALL be 1 and a 9-bit counter SHALL count GAP_CYC cycles.
REQ-027 When the GAP count completes, the block SHALL return to IDLE, with the counter cleared on GAP entry.
REQ-028 Requests arriving during SEND or GAP SHALL wait and be arbitrated in the first IDLE cycle, so back-to-back frames are spaced by at least GAP_CYC+1 cycles.
REQ-029 Grant-to-start-bit latency SHALL be 1 cycle (IDLE to SEND) plus the generator's half-bit delay; the line SHALL stay high until the first strobe.
REQ-030 a_ack and b_ack SHALL never be high in the same cycle, and at most one ack SHALL occur per frame.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately force all of the following, even mid-frame:
- state=IDLE, tx=1, tx_flag=0
- a_ack=0, b_ack=0, busy=0, frame_done=0
- data register=0, gap counter=0, last-grant=B
REQ-032 A frame interrupted by reset SHALL be abandoned and not resumed.
REQ-033 After reset release, the first grant SHALL be possible in the first clock edge at which rst_n is high.

Verification
REQ-034 Scenario, single A send: A sends 0x55 alone -> a_ack pulses once; at the strobes tx reads 0,1,0,1,0,1,0,1,0,1; frame_done pulses once; busy returns 0 after the gap.
REQ-035 Scenario, simultaneous requests: a_req (0xA5) and b_req (0x3C) rise in the same cycle -> a_ack first, A frame, then GAP_CYC idle cycles, then b_ack and the 0x3C frame (data bits 0,0,1,1,1,1,0,0).
REQ-036 Scenario, fairness: A holds req continuously with B pending -> grants alternate A,B,A; no requester is granted twice while the other waits.
REQ-037 Scenario, reset mid-frame: assert rst_n=0 at tx_bit_cnt==4 -> tx=1 and tx_flag=0 asynchronously; after release, a fresh frame for a pending request starts cleanly.
REQ-038 Scenario, withdrawn request: b_req is pulsed high for 1 cycle while busy=1 and dropped before IDLE -> no b_ack, no frame, busy falls after the gap.
REQ-039 Scenario, stop-bit spacing: back-to-back A bytes -> the interval from frame_done to the next falling start edge is at least GAP_CYC + 218 cycles.
